// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state types and framing constants for the 8N1 UART.
package uart_pkg;
    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    typedef enum logic [1:0] {RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running dividers giving one-cycle bit ticks (tx) and 16x oversample ticks (rx).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic clk_50m,
    input  logic rst_n,
    output logic tx_tick,
    output logic rx_tick
);
    localparam int TX_DIV = CLK_FREQ / BAUD;
    localparam int RX_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TW     = TX_DIV > 1 ? $clog2(TX_DIV) : 1;
    localparam int RW     = RX_DIV > 1 ? $clog2(RX_DIV) : 1;

    logic [TW-1:0] tx_cnt_q, tx_cnt_d;
    logic [RW-1:0] rx_cnt_q, rx_cnt_d;

    always_comb begin
        tx_tick  = tx_cnt_q == TW'(TX_DIV - 1);
        rx_tick  = rx_cnt_q == RW'(RX_DIV - 1);
        tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
        rx_cnt_d = rx_tick ? '0 : rx_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end
endmodule

// File: rtl/uart.sv
// uart: full-duplex 8N1 UART; bit-tick transmitter and 16x oversampling receiver with ready/clear handshake.
module uart
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic       rdy,
    input  logic       rdy_clr,
    output logic [7:0] dout
);
    logic tx_tick, rx_tick;

    uart_baud_gen #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_baud (
        .clk_50m(clk_50m),
        .rst_n  (rst_n),
        .tx_tick(tx_tick),
        .rx_tick(rx_tick)
    );

    tx_state_t  tx_state_q, tx_state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [3:0] tx_bit_q, tx_bit_d;
    logic       tx_q, tx_d;

    // tx_bit_q keeps counting through STOP so the stop bit lasts a full period
    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        case (tx_state_q)
            IDLE: if (wr_en) begin
                tx_data_d  = din;
                tx_state_d = START;
            end
            START: if (tx_tick) begin
                tx_d       = 1'b0;
                tx_bit_d   = '0;
                tx_state_d = DATA;
            end
            DATA: if (tx_tick) begin
                tx_d       = tx_data_q[tx_bit_q[2:0]];
                tx_bit_d   = tx_bit_q + 4'd1;
                tx_state_d = tx_bit_q == 4'(DATA_BITS - 1) ? STOP : DATA;
            end
            STOP: if (tx_tick) begin
                tx_d       = 1'b1;
                tx_bit_d   = tx_bit_q + 4'd1;
                tx_state_d = tx_bit_q == 4'(DATA_BITS + 1) ? IDLE : STOP;
            end
            default: tx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= IDLE;
            tx_data_q  <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = tx_state_q != IDLE;

    rx_state_t  rx_state_q, rx_state_d;
    logic       rx_s1_q, rx_s2_q;
    logic [3:0] rx_samp_q, rx_samp_d;
    logic [3:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] dout_q, dout_d;
    logic       rdy_q, rdy_d, rx_set;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_samp_d  = rx_samp_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        dout_d     = dout_q;
        rx_set     = 1'b0;
        if (rx_tick) begin
            case (rx_state_q)
                RX_START: if (rx_samp_q == '0) begin
                    rx_samp_d = {3'b000, ~rx_s2_q};
                end else if (rx_samp_q == 4'(OVERSAMPLE / 2 - 1)) begin
                    // mid start bit: a line back high here was only a glitch
                    rx_samp_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_START : RX_DATA;
                end else begin
                    rx_samp_d = rx_samp_q + 4'd1;
                end
                RX_DATA: if (rx_samp_q == 4'(OVERSAMPLE - 1)) begin
                    rx_samp_d  = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 4'd1;
                    rx_state_d = rx_bit_q == 4'(DATA_BITS - 1) ? RX_STOP : RX_DATA;
                end else begin
                    rx_samp_d = rx_samp_q + 4'd1;
                end
                RX_STOP: if (rx_samp_q == 4'(OVERSAMPLE - 1)) begin
                    rx_samp_d  = '0;
                    rx_state_d = RX_START;
                    rx_set     = rx_s2_q;
                    dout_d     = rx_s2_q ? rx_shift_q : dout_q;
                end else begin
                    rx_samp_d = rx_samp_q + 4'd1;
                end
                default: rx_state_d = RX_START;
            endcase
        end
        rdy_d = rx_set | (rdy_q & ~rdy_clr);
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= RX_START;
            rx_samp_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            dout_q     <= '0;
            rdy_q      <= 1'b0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_samp_q  <= rx_samp_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            dout_q     <= dout_d;
            rdy_q      <= rdy_d;
        end
    end

    assign rdy  = rdy_q;
    assign dout = dout_q;
endmodule

// File: tb/tb_uart.sv
// tb_uart: directed and random-byte checks of the UART against a bit-level line model.
module tb_uart;
    localparam int CF = 1_600_000;
    localparam int BD = 100_000;
    localparam int T  = CF / BD;
    localparam int RT = CF / (BD * 16);

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wr_en = 1'b0, rdy_clr = 1'b0, rx_drv = 1'b1, loop = 1'b0;
    logic       tx, tx_busy, rdy, rx;
    logic [7:0] dout;
    int         total = 0, bad = 0;

    assign rx = loop ? tx : rx_drv;

    uart #(.CLK_FREQ(CF), .BAUD(BD)) dut (
        .clk_50m(clk),
        .rst_n  (rst_n),
        .din    (din),
        .wr_en  (wr_en),
        .tx     (tx),
        .tx_busy(tx_busy),
        .rx     (rx),
        .rdy    (rdy),
        .rdy_clr(rdy_clr),
        .dout   (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input logic [7:0] b);
        din   = b;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic clear_rdy();
        rdy_clr = 1'b1;
        @(negedge clk);
        rdy_clr = 1'b0;
    endtask

    // serialise one frame onto rx; a bad stop bit is held low just past mid-bit
    task automatic send_rx(input logic [7:0] b, input bit stop_ok);
        rx_drv = 1'b0;
        cyc(T);
        for (int k = 0; k < 8; k++) begin
            rx_drv = b[k];
            cyc(T);
        end
        rx_drv = stop_ok;
        cyc(stop_ok ? T : T / 2 + 2);
        rx_drv = 1'b1;
        cyc(2 * T);
    endtask

    // expected line level i cycles after the start edge is derived from frame position alone
    task automatic grab_frame(input string tag, input logic [7:0] exp, input int inj);
        int w = 0, errs = 0;
        logic [7:0] got = 8'h00;
        logic lvl;
        while (tx !== 1'b0 && w < 3 * T) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("%s_start", tag), tx, 1'b0);
        for (int i = 0; i < 10 * T; i++) begin
            lvl = i < T ? 1'b0 : i < 9 * T ? exp[i / T - 1] : 1'b1;
            if (tx !== lvl) errs++;
            if (tx_busy !== 1'b1) errs++;
            if (i >= T && i < 9 * T && i % T == T / 2) got[i / T - 1] = tx;
            din   = i == inj ? 8'hFF : din;
            wr_en = i == inj;
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk($sformatf("%s_wave", tag), errs, 0);
        chk($sformatf("%s_byte", tag), got, exp);
        chk($sformatf("%s_busy_fall", tag), tx_busy, 1'b0);
    endtask

    initial begin
        int lows, w, last;
        logic [7:0] b;
        cyc(3);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_rdy", rdy, 1'b0);
        chk("rst_dout", dout, 8'h00);
        rst_n = 1'b1;
        cyc(2);

        chk("a5_busy_pre", tx_busy, 1'b0);
        write(8'hA5);
        chk("a5_busy_rise", tx_busy, 1'b1);
        grab_frame("a5", 8'hA5, -1);

        cyc(3);
        write(8'h3C);
        grab_frame("3c", 8'h3C, 3 * T);
        lows = 0;
        for (int i = 0; i < 4 * T; i++) begin
            if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
            @(negedge clk);
        end
        chk("3c_no_second", lows, 0);

        send_rx(8'h55, 1'b1);
        chk("r55_rdy", rdy, 1'b1);
        chk("r55_dout", dout, 8'h55);
        cyc(3 * T);
        chk("r55_rdy_hold", rdy, 1'b1);
        clear_rdy();
        chk("r55_rdy_clr", rdy, 1'b0);
        chk("r55_dout_keep", dout, 8'h55);

        rx_drv = 1'b0;
        cyc(4 * RT);
        rx_drv = 1'b1;
        cyc(2 * T);
        chk("glitch_no_rdy", rdy, 1'b0);
        send_rx(8'h81, 1'b1);
        chk("r81_rdy", rdy, 1'b1);
        chk("r81_dout", dout, 8'h81);
        clear_rdy();

        send_rx(8'h7E, 1'b0);
        chk("ferr_rdy", rdy, 1'b0);
        chk("ferr_dout", dout, 8'h81);

        loop = 1'b1;
        last = -1;
        for (int n = 0; n < 256; n++) begin
            b = 8'(n);
            w = 0;
            while (tx_busy && w < 4 * T) begin
                @(negedge clk);
                w++;
            end
            write(b);
            w = 0;
            while (!rdy && w < 20 * T) begin
                @(negedge clk);
                w++;
            end
            chk($sformatf("lb_rdy_%0d", n), rdy, 1'b1);
            if (rdy !== 1'b1) break;
            chk($sformatf("lb_dout_%0d", n), dout, b);
            if (dout === b) last = n;
            clear_rdy();
        end
        chk("lb_last", last, 255);
        cyc(2 * T);
        loop = 1'b0;

        write(8'h5A);
        w = 0;
        while (tx !== 1'b0 && w < 3 * T) begin
            @(negedge clk);
            w++;
        end
        cyc(3 * T);
        chk("mid_busy_pre", tx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_busy", tx_busy, 1'b0);
        chk("mid_rst_dout", dout, 8'h00);
        cyc(2);
        rst_n = 1'b1;
        cyc(4 * T);
        chk("post_rst_idle", tx, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart.md
Name: uart

Overview:
- Full-duplex 8N1 UART: one transmitter and one receiver, sharing one clock and one baud generator.
- Parallel byte in → serial `tx`; serial `rx` → parallel byte out, with a ready/clear handshake.
- Sits between the system bus logic (50 MHz domain) and the external serial pins. `tx` may be looped back to `rx` for self-test.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- TX_DIV (derived), CLK_FREQ/BAUD = 434, clocks per transmitted bit.
- RX_DIV (derived), CLK_FREQ/(BAUD*16) = 27, clocks per receive oversample tick.

Ports:
- clk_50m  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  8  byte to transmit; sampled on an accepted `wr_en`.
- wr_en  in  1  one-cycle write strobe.
- tx  out  1  serial output; idle high.
- tx_busy  out  1  high while a frame is in progress.
- rx  in  1  serial input, asynchronous to `clk_50m`.
- rdy  out  1  received byte valid in `dout`.
- rdy_clr  in  1  clears `rdy`.
- dout  out  8  last received byte.

Behaviour:
Reset (while `rst_n`=0):
- `tx`=1, `tx_busy`=0, `rdy`=0, `dout`=0.
- TX FSM goes to IDLE and RX FSM goes to START.
- Baud counters are cleared.
- Reset mid-frame aborts the frame immediately; no partial byte is delivered.

Baud generator:
- Free-running counters produce a one-cycle `tx_tick` every TX_DIV clocks and a `rx_tick` every RX_DIV clocks.

Transmitter FSM (IDLE, START, DATA, STOP):
- IDLE: `wr_en`=1 latches `din` and moves to START. `tx_busy` goes high on the next clock edge.
- START: on `tx_tick`, drive `tx`=0 for one bit period.
- DATA: 8 bits, LSB first, one per `tx_tick`.
- STOP: drive `tx`=1 for one bit period, then return to IDLE; `tx_busy` falls.
- `wr_en` while `tx_busy`=1 is ignored; the in-flight byte is unchanged.
- Frame is 10 bit periods (~4340 clocks at the default parameters).

Receiver (16x oversampling, all actions on `rx_tick`):
- `rx` passes through a 2-flop synchronizer before use.
- START: wait for `rx` low. Re-check at sample 8 (mid-bit). If `rx` is high again, treat it as a glitch: reset the sample count and stay in START.
- DATA: sample each bit at its mid-point (every 16 ticks). Shift in LSB first.
- STOP: sample mid-stop.
  - If 1: copy shift register to `dout` and set `rdy`=1.
  - If 0 (framing error): discard the byte; `dout` and `rdy` are unchanged.
  - Either way, return to START.
- `rdy` stays high until `rdy_clr`=1. A new byte overwrites `dout` even if `rdy` is still high (no overrun flag).
- If `rdy_clr` and a new-byte set occur in the same cycle, the set wins and `rdy` stays 1.
- TX and RX operate fully independently; a simultaneous transmit and receive is legal.

Decomposition:
- Package `uart_pkg` holds:
  - `tx_state_t` enum {IDLE, START, DATA, STOP};
  - `rx_state_t` enum {RX_START, RX_DATA, RX_STOP};
  - constants DATA_BITS=8 and OVERSAMPLE=16.
- One sub-module, `uart_baud_gen` (parameters CLK_FREQ and BAUD; outputs `tx_tick` and `rx_tick`).
- The TX and RX FSMs live in the `uart` top.

Test Plan:
- Loopback (`tx` tied to `rx`): send bytes 0x00..0xFF, one `wr_en` per byte issued after each `rdy`, with `rdy_clr` pulsed. Every `dout` must equal the byte sent; pass once 0xFF is verified.
- Single write of 0xA5: `tx_busy` rises on the next edge. `tx` shows 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, each bit TX_DIV clocks wide. `tx_busy` falls after the stop bit.
- Write 0x3C, then pulse `wr_en` with `din`=0xFF mid-frame: the line carries only 0x3C, and no second frame follows.
- Receive 0x55 and hold `rdy_clr`=0: `rdy` stays 1. Pulse `rdy_clr`: `rdy`=0 next cycle, and `dout` keeps 0x55.
- Drive `rx` low for 4 oversample ticks, then high: no `rdy`, and the receiver still correctly captures a following 0x81 frame.
- Send 0x7E with the stop bit forced to 0: `rdy` stays 0 and `dout` keeps its old value. Assert `rst_n`=0 mid-TX-frame: `tx`=1 and `tx_busy`=0 immediately.
